// File: rtl/dmem_responder.sv
// Word-addressed data RAM for the Memory stage, with an IDLE/WAIT/RESP request handshake.
// Latency: a request accepted at edge t completes at edge t+LATENCY; MemReadyM is high for the cycle after that edge.
// Backpressure: at most one access in flight; MemReqM is ignored while BusyM=1, and the pipeline stalls on BusyM.
module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int ADDR_W  = 6,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        MemReadyM,
    output logic        MemFaultM,
    output logic        BusyM
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0]  LAT_M1  = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    state_t              state, state_nxt;
    logic [3:0]          cnt, cnt_nxt;
    logic                capture;
    logic [31:0]         addr_q, wdat_q;
    logic                wr_q;
    logic [31:0]         acc_addr, acc_wdat;
    logic                acc_wr, acc_fault, enter_resp;
    logic [ADDR_W-1:0]   acc_idx;
    logic [31:0]         mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (MemReqM) begin
                    capture = 1'b1;
                    if (LATENCY == 0) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = LAT_M1;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_nxt = RESP;
                else             cnt_nxt   = cnt - 4'd1;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        enter_resp = (state_nxt == RESP);
    end

    // With zero wait states the access completes on the accepting edge, before the capture registers load.
    always_comb begin
        acc_addr  = (state == IDLE) ? ALUOutM    : addr_q;
        acc_wdat  = (state == IDLE) ? WriteDataM : wdat_q;
        acc_wr    = (state == IDLE) ? MemWriteM  : wr_q;
        acc_fault = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= DEPTH_W);
        acc_idx   = acc_addr[ADDR_W+1:2];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
            wdat_q <= '0;
            wr_q   <= 1'b0;
        end else if (capture) begin
            addr_q <= ALUOutM;
            wdat_q <= WriteDataM;
            wr_q   <= MemWriteM;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ReadDataM <= '0;
            MemReadyM <= 1'b0;
            MemFaultM <= 1'b0;
            BusyM     <= 1'b0;
        end else begin
            MemReadyM <= enter_resp;
            MemFaultM <= enter_resp && acc_fault;
            BusyM     <= (state_nxt != IDLE);
            if (enter_resp) begin
                ReadDataM <= acc_fault ? 32'd0 : (acc_wr ? acc_wdat : mem[acc_idx]);
            end
        end
    end

    // RAM contents survive reset; a store only lands on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (reset && enter_resp && acc_wr && !acc_fault) begin
            mem[acc_idx] <= acc_wdat;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder: a word-array reference model predicts each response,
// a monitor pops and compares on every MemReadyM pulse; two extra instances check LATENCY=0/3 throughput.
module tb_dmem_responder;

    localparam int DEPTH = 64;
    localparam int LAT   = 2;

    typedef struct {
        logic [31:0] data;
        logic        fault;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemReqM = 1'b0, MemWriteM = 1'b0;
    logic [31:0] ALUOutM = '0, WriteDataM = '0;
    logic [31:0] ReadDataM;
    logic        MemReadyM, MemFaultM, BusyM;

    logic        req_t = 1'b1, wr_t = 1'b0;
    logic [31:0] addr_t = 32'h0000_0104, wdat_t = '0;
    logic [31:0] rd0, rd3;
    logic        rdy0, flt0, busy0, rdy3, flt3, busy3;

    int          checks = 0, errors = 0, cyc = 0;
    bit          tm_done = 1'b0;
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] last_rd = '0;
    exp_t        sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    dmem_responder #(.DEPTH(DEPTH), .ADDR_W(6), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .MemReqM(MemReqM), .MemWriteM(MemWriteM),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM),
        .MemReadyM(MemReadyM), .MemFaultM(MemFaultM), .BusyM(BusyM));

    dmem_responder #(.DEPTH(DEPTH), .ADDR_W(6), .LATENCY(0)) dut_l0 (
        .clk(clk), .reset(reset), .MemReqM(req_t), .MemWriteM(wr_t),
        .ALUOutM(addr_t), .WriteDataM(wdat_t), .ReadDataM(rd0),
        .MemReadyM(rdy0), .MemFaultM(flt0), .BusyM(busy0));

    dmem_responder #(.DEPTH(DEPTH), .ADDR_W(6), .LATENCY(3)) dut_l3 (
        .clk(clk), .reset(reset), .MemReqM(req_t), .MemWriteM(wr_t),
        .ALUOutM(addr_t), .WriteDataM(wdat_t), .ReadDataM(rd3),
        .MemReadyM(rdy3), .MemFaultM(flt3), .BusyM(busy3));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Present one request; the model decides the outcome from the address rules and the word array.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input bit directed);
        exp_t e;
        int   idx;
        @(negedge clk);
        MemReqM = 1'b1; MemWriteM = wr; ALUOutM = addr; WriteDataM = data;
        @(posedge clk);
        #1;
        e.cyc = cyc + LAT;
        if (addr[1:0] != 2'b00 || {2'b00, addr[31:2]} >= 32'(DEPTH)) begin
            e.data = '0; e.fault = 1'b1;
        end else begin
            idx = int'(addr[31:2]);
            if (wr) begin
                ref_mem[idx] = data;
                e.data = data;
            end else begin
                e.data = ref_mem[idx];
            end
            e.fault = 1'b0;
        end
        sb.push_back(e);
        // Inputs seen by the WAIT and RESP edges must have no effect.
        for (int k = 0; k < LAT + 1; k++) begin
            @(negedge clk);
            if (directed) begin
                ALUOutM = addr + 32'd4; WriteDataM = '0;
            end else begin
                MemReqM = 1'($urandom_range(0, 1)); MemWriteM = 1'($urandom_range(0, 1));
                ALUOutM = $urandom; WriteDataM = $urandom;
            end
            @(posedge clk);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            MemReqM = 1'b0; ALUOutM = $urandom; WriteDataM = $urandom;
            @(posedge clk);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0:       a = $urandom;
            1:       a = {24'd0, 6'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
            2:       a = 32'($urandom_range(DEPTH, 4 * DEPTH)) << 2;
            default: a = 32'($urandom_range(0, DEPTH - 1)) << 2;
        endcase
        return a;
    endfunction

    // Monitor: compares each completion against the oldest prediction, and checks hold behaviour between.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                last_rd = '0;
            end else if (MemReadyM) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ready: got MemReadyM=1 expected no response (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("rdata", ReadDataM, e.data);
                    chk("fault", {31'd0, MemFaultM}, {31'd0, e.fault});
                    chk("ready_cycle", 32'(cyc), 32'(e.cyc));
                    chk("busy_in_resp", {31'd0, BusyM}, 32'd1);
                    last_rd = e.data;
                end
            end else begin
                chk("fault_clear", {31'd0, MemFaultM}, 32'd0);
                chk("rdata_hold", ReadDataM, last_rd);
            end
        end
    end

    // Throughput with MemReqM held high: period LATENCY+2, exactly one BusyM-low cycle between accesses.
    initial begin
        int last0 = -1, last3 = -1, bl0 = 0, bl3 = 0, n0 = 0, n3 = 0;
        wait (reset === 1'b1);
        repeat (40) begin
            @(negedge clk);
            #1;
            if (rdy0) begin
                if (last0 >= 0) begin
                    chk("l0_period", 32'(cyc - last0), 32'd2);
                    chk("l0_busy_gap", 32'(bl0), 32'd1);
                end
                last0 = cyc; bl0 = 0; n0++;
            end else if (!busy0) bl0++;
            if (rdy3) begin
                if (last3 >= 0) begin
                    chk("l3_period", 32'(cyc - last3), 32'd5);
                    chk("l3_busy_gap", 32'(bl3), 32'd1);
                end
                last3 = cyc; bl3 = 0; n3++;
            end else if (!busy3) bl3++;
        end
        chk("l0_pulse_count", {31'd0, n0 >= 15}, 32'd1);
        chk("l3_pulse_count", {31'd0, n3 >= 7}, 32'd1);
        tm_done = 1'b1;
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rdata", ReadDataM, 32'd0);
        chk("rst_ready", {31'd0, MemReadyM}, 32'd0);
        chk("rst_fault", {31'd0, MemFaultM}, 32'd0);
        chk("rst_busy", {31'd0, BusyM}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < DEPTH; i++) issue(1'b1, 32'(i * 4), $urandom, 1'b0);

        issue(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        issue(1'b0, 32'h10, 32'h0, 1'b0);
        issue(1'b1, 32'h13, 32'h12345678, 1'b0);
        issue(1'b0, 32'h10, 32'h0, 1'b0);
        issue(1'b0, 32'h100, 32'h0, 1'b0);
        issue(1'b0, 32'hFC, 32'h0, 1'b0);
        issue(1'b1, 32'h20, 32'hAAAA5555, 1'b1);
        issue(1'b0, 32'h20, 32'h0, 1'b0);
        issue(1'b0, 32'h24, 32'h0, 1'b0);

        // Store accepted, then reset one cycle later: it must never reach the RAM.
        @(negedge clk);
        MemReqM = 1'b1; MemWriteM = 1'b1; ALUOutM = 32'h30; WriteDataM = 32'h11111111;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; MemReqM = 1'b0;
        #1;
        chk("midrst_rdata", ReadDataM, 32'd0);
        chk("midrst_ready", {31'd0, MemReadyM}, 32'd0);
        chk("midrst_fault", {31'd0, MemFaultM}, 32'd0);
        chk("midrst_busy", {31'd0, BusyM}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        issue(1'b0, 32'h30, 32'h0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            issue(1'($urandom_range(0, 1)), rand_addr(), $urandom, 1'b0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(1);

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: got %0d responses outstanding expected 0", sb.size());
        end
        n = 0;
        while (!tm_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!tm_done) begin
            checks++; errors++;
            $display("FAIL throughput_window: got incomplete expected complete");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
